// File: rtl/onchip_sram_dp_pipe.sv
// ---------------------------------------------------------------------------
// onchip_sram_dp_pipe
//
// True dual-port on-chip SRAM with two independent Avalon-MM slave ports
// (port A = s1, port B = s2) sharing one clock. Width and depth are generic.
// Read latency is 1 or 2 registered cycles and is signalled by readdatavalid.
//
// Behaviour summary:
//   - Same-address writes from both ports are resolved per byte. Port A wins
//     where both lanes are enabled.
//   - A read of an address the other port writes in the same cycle sees the
//     writer's new bytes on the enabled lanes.
//   - reset_req freezes the whole block. No accepts, no writes, and the read
//     pipelines hold. readdatavalid is masked low while it is asserted.
//
// Parameters:
//   DATA_W    data width per port, multiple of 8
//   ADDR_W    word address width, depth = 2**ADDR_W
//   READ_LAT  read latency in cycles (1 or 2)
//   INIT_FILE hex init file name for the vendor memory-init flow; contents
//             start at zero here
//
// Ports:
//   clk, reset (async, active-high), reset_req (global freeze)
//   chipselect/address/byteenable/read/write/writedata/clken         port A in
//   chipselect2/address2/byteenable2/read2/write2/writedata2/clken2  port B in
//   readdata/readdatavalid, readdata2/readdatavalid2                 read returns
//   wr_collision   one-cycle pulse after an overlapping same-address write
//
// Optional build macro ONCHIP_SRAM_DP_PARITY_EN:
//   When defined, one even-parity bit is stored per byte. parity_inject
//   inverts the stored parity of every byte being written. parity_err and
//   parity_err2 flag a parity mismatch alongside readdatavalid and
//   readdatavalid2.
// ---------------------------------------------------------------------------
module onchip_sram_dp_pipe #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 6,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic                chipselect,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  input  logic                chipselect2,
  input  logic [ADDR_W-1:0]   address2,
  input  logic [DATA_W/8-1:0] byteenable2,
  input  logic                read2,
  input  logic                write2,
  input  logic [DATA_W-1:0]   writedata2,
  input  logic                clken2,
  output logic [DATA_W-1:0]   readdata2,
  output logic                readdatavalid2,
  output logic                wr_collision
`ifdef ONCHIP_SRAM_DP_PARITY_EN
  ,
  input  logic                parity_inject,
  output logic                parity_err,
  output logic                parity_err2
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [1:0]        acc;
  logic [1:0]        acc_wr;
  logic [1:0]        acc_rd;
  logic [ADDR_W-1:0] addr_p [2];
  logic [NB-1:0]     be_p [2];
  logic [DATA_W-1:0] wd_p [2];
  logic [NB-1:0]     we_a;
  logic [NB-1:0]     we_b;
  logic              same_addr;
  logic [DATA_W-1:0] rd_merge [2];

  // Fold both Avalon ports into small arrays so the rest of the datapath can
  // treat them symmetrically. A port accepts only when it is selected and
  // enabled, and the block is neither frozen nor in reset. When read and
  // write are both asserted, the write goes through and the read is dropped.
  always_comb begin
    acc[0]    = chipselect  & clken  & ~reset_req & ~reset;
    acc[1]    = chipselect2 & clken2 & ~reset_req & ~reset;
    acc_wr[0] = acc[0] & write;
    acc_wr[1] = acc[1] & write2;
    acc_rd[0] = acc[0] & read  & ~write;
    acc_rd[1] = acc[1] & read2 & ~write2;
    addr_p[0] = address;
    addr_p[1] = address2;
    be_p[0]   = byteenable;
    be_p[1]   = byteenable2;
    wd_p[0]   = writedata;
    wd_p[1]   = writedata2;
  end

  // Per-byte write enables with port A priority. When both ports hit the
  // same word, port B loses every lane that port A also writes. This way the
  // memory never sees two writes to one byte.
  always_comb begin
    same_addr = (addr_p[0] == addr_p[1]);
    we_a      = acc_wr[0] ? be_p[0] : '0;
    we_b      = acc_wr[1] ? be_p[1] : '0;
    if (acc_wr[0] && same_addr) begin
      we_b = we_b & ~be_p[0];
    end
  end

  // Collision flag registered from this cycle's accepted writes. The flag
  // fires only when the byte masks actually overlap on the same word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_collision <= 1'b0;
    end else begin
      wr_collision <= acc_wr[0] & acc_wr[1] & same_addr & (|(be_p[0] & be_p[1]));
    end
  end

  // Storage array. It has no reset, so contents survive an async reset.
  // Both ports update their enabled bytes at the edge that ends the accept
  // cycle.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we_a[b]) begin
        mem[addr_p[0]][b*8 +: 8] <= wd_p[0][b*8 +: 8];
      end
      if (we_b[b]) begin
        mem[addr_p[1]][b*8 +: 8] <= wd_p[1][b*8 +: 8];
      end
    end
  end

  // Read value as launched into the pipeline. Start from the stored word,
  // then overlay any byte being written this cycle to the same address,
  // port A first. This gives mixed-port forwarding and the A-priority merge
  // on collisions.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_merge[p] = mem[addr_p[p]];
      for (int b = 0; b < NB; b++) begin
        if (we_a[b] && (addr_p[0] == addr_p[p])) begin
          rd_merge[p][b*8 +: 8] = wd_p[0][b*8 +: 8];
        end else if (we_b[b] && (addr_p[1] == addr_p[p])) begin
          rd_merge[p][b*8 +: 8] = wd_p[1][b*8 +: 8];
        end
      end
    end
  end

`ifdef ONCHIP_SRAM_DP_PARITY_EN
  logic [NB-1:0] pmem [DEPTH] = '{default: '0};
  logic [NB-1:0] wpar [2];
  logic [NB-1:0] rpar [2];
  logic [1:0]    rd_perr;

  // Parity bit to store for each written byte. It is the even parity of the
  // byte, optionally inverted so error handling downstream can be exercised.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < NB; b++) begin
        wpar[p][b] = (^wd_p[p][b*8 +: 8]) ^ parity_inject;
      end
    end
  end

  // Parity storage follows exactly the same per-byte enables as the data.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we_a[b]) begin
        pmem[addr_p[0]][b] <= wpar[0][b];
      end
      if (we_b[b]) begin
        pmem[addr_p[1]][b] <= wpar[1][b];
      end
    end
  end

  // Stored parity is forwarded with the same priority as the data. It is
  // then compared against parity recomputed from the merged read word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rpar[p] = pmem[addr_p[p]];
      for (int b = 0; b < NB; b++) begin
        if (we_a[b] && (addr_p[0] == addr_p[p])) begin
          rpar[p][b] = wpar[0][b];
        end else if (we_b[b] && (addr_p[1] == addr_p[p])) begin
          rpar[p][b] = wpar[1][b];
        end
      end
      rd_perr[p] = 1'b0;
      for (int b = 0; b < NB; b++) begin
        rd_perr[p] = rd_perr[p] | ((^rd_merge[p][b*8 +: 8]) ^ rpar[p][b]);
      end
    end
  end
`endif

  // One read return pipeline per port.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              s_v;
    logic [DATA_W-1:0] s_d;
    logic              o_v;
    logic [DATA_W-1:0] o_d;
`ifdef ONCHIP_SRAM_DP_PARITY_EN
    logic              s_e;
    logic              o_e;
`endif

    if (READ_LAT == 2) begin : g_lat2
      // Extra stage for the two-cycle latency build. It freezes under
      // reset_req. Data is loaded only with a valid read, so stale words
      // are never shifted forward.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s_v <= 1'b0;
          s_d <= '0;
`ifdef ONCHIP_SRAM_DP_PARITY_EN
          s_e <= 1'b0;
`endif
        end else if (!reset_req) begin
          s_v <= acc_rd[p];
          if (acc_rd[p]) begin
            s_d <= rd_merge[p];
`ifdef ONCHIP_SRAM_DP_PARITY_EN
            s_e <= rd_perr[p];
`endif
          end
        end
      end
    end else begin : g_lat1
      assign s_v = acc_rd[p];
      assign s_d = rd_merge[p];
`ifdef ONCHIP_SRAM_DP_PARITY_EN
      assign s_e = rd_perr[p];
`endif
    end

    // Output register. readdata only changes on a real return, so it holds
    // its last value between returns. Under reset_req the pending valid is
    // held, and it reappears once the freeze lifts.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        o_v <= 1'b0;
        o_d <= '0;
`ifdef ONCHIP_SRAM_DP_PARITY_EN
        o_e <= 1'b0;
`endif
      end else if (!reset_req) begin
        o_v <= s_v;
        if (s_v) begin
          o_d <= s_d;
`ifdef ONCHIP_SRAM_DP_PARITY_EN
          o_e <= s_e;
`endif
        end
      end
    end
  end

  assign readdata       = g_port[0].o_d;
  assign readdata2      = g_port[1].o_d;
  assign readdatavalid  = g_port[0].o_v & ~reset_req;
  assign readdatavalid2 = g_port[1].o_v & ~reset_req;
`ifdef ONCHIP_SRAM_DP_PARITY_EN
  assign parity_err     = g_port[0].o_e;
  assign parity_err2    = g_port[1].o_e;
`endif

endmodule

// File: tb/tb_onchip_sram_dp_pipe.sv
// ---------------------------------------------------------------------------
// tb_onchip_sram_dp_pipe
//
// Two instances of the dual-port SRAM are driven with identical stimulus:
// dut1 uses READ_LAT=1 and dut2 uses READ_LAT=2. Every accepted read pushes
// its expected word to a per-instance, per-port queue. Each entry carries the
// number of unfrozen clock edges still needed before it is due. A negedge
// monitor compares readdatavalid on every cycle, compares readdata on every
// due return, and also compares wr_collision.
// Queue index: 0 = dut1 A, 1 = dut1 B, 2 = dut2 A, 3 = dut2 B.
// ---------------------------------------------------------------------------
module tb_onchip_sram_dp_pipe;

  typedef struct {
    logic [15:0] data;
    int          left;
  } rd_item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset_req;
  logic        a_cs, a_rd, a_wr, a_ck;
  logic [5:0]  a_addr;
  logic [1:0]  a_be;
  logic [15:0] a_wd;
  logic        b_cs, b_rd, b_wr, b_ck;
  logic [5:0]  b_addr;
  logic [1:0]  b_be;
  logic [15:0] b_wd;

  logic [15:0] rdat [4];
  logic        rvalid [4];
  logic        coll [2];

  logic [15:0] ref_mem [64];
  rd_item_t    sb [4][$];
  logic        exp_coll;
  int          check_cnt;
  int          pass_cnt;

`ifdef ONCHIP_SRAM_DP_PARITY_EN
  logic        perr [4];
`endif

  always #5 clk = ~clk;

  onchip_sram_dp_pipe #(.DATA_W(16), .ADDR_W(6), .READ_LAT(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .chipselect(a_cs), .address(a_addr), .byteenable(a_be), .read(a_rd),
    .write(a_wr), .writedata(a_wd), .clken(a_ck),
    .readdata(rdat[0]), .readdatavalid(rvalid[0]),
    .chipselect2(b_cs), .address2(b_addr), .byteenable2(b_be), .read2(b_rd),
    .write2(b_wr), .writedata2(b_wd), .clken2(b_ck),
    .readdata2(rdat[1]), .readdatavalid2(rvalid[1]),
    .wr_collision(coll[0])
`ifdef ONCHIP_SRAM_DP_PARITY_EN
    , .parity_inject(1'b0), .parity_err(perr[0]), .parity_err2(perr[1])
`endif
  );

  onchip_sram_dp_pipe #(.DATA_W(16), .ADDR_W(6), .READ_LAT(2), .INIT_FILE("")) dut2 (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .chipselect(a_cs), .address(a_addr), .byteenable(a_be), .read(a_rd),
    .write(a_wr), .writedata(a_wd), .clken(a_ck),
    .readdata(rdat[2]), .readdatavalid(rvalid[2]),
    .chipselect2(b_cs), .address2(b_addr), .byteenable2(b_be), .read2(b_rd),
    .write2(b_wr), .writedata2(b_wd), .clken2(b_ck),
    .readdata2(rdat[3]), .readdatavalid2(rvalid[3]),
    .wr_collision(coll[1])
`ifdef ONCHIP_SRAM_DP_PARITY_EN
    , .parity_inject(1'b0), .parity_err(perr[2]), .parity_err2(perr[3])
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns the word a reader of address ad should see this cycle. It starts
  // from the stored contents, then overlays the bytes written this cycle,
  // with A-priority.
  function automatic logic [15:0] merged(input logic [5:0] ad, input logic wa, input logic wb);
    logic [15:0] v;
    v = ref_mem[ad];
    for (int b = 0; b < 2; b++) begin
      if (wa && a_addr == ad && a_be[b]) begin
        v[b*8 +: 8] = a_wd[b*8 +: 8];
      end else if (wb && b_addr == ad && b_be[b]) begin
        v[b*8 +: 8] = b_wd[b*8 +: 8];
      end
    end
    return v;
  endfunction

  task automatic set_a(input logic r, input logic w, input logic [5:0] ad,
                       input logic [15:0] d, input logic [1:0] be);
    a_cs = 1'b1; a_rd = r; a_wr = w; a_addr = ad; a_wd = d; a_be = be;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [5:0] ad,
                       input logic [15:0] d, input logic [1:0] be);
    b_cs = 1'b1; b_rd = r; b_wr = w; b_addr = ad; b_wd = d; b_be = be;
  endtask

  task automatic clear_requests();
    a_rd = 1'b0; a_wr = 1'b0; a_ck = 1'b1; a_cs = 1'b1;
    b_rd = 1'b0; b_wr = 1'b0; b_ck = 1'b1; b_cs = 1'b1;
  endtask

  // Drives the currently set inputs through one clock edge. It predicts the
  // read returns and the collision flag, then updates the reference memory.
  task automatic applyStimulus();
    logic acc_a, acc_b, wa, wb, ra, rb, cn;
    rd_item_t it;
    acc_a = a_cs & a_ck & ~reset_req;
    acc_b = b_cs & b_ck & ~reset_req;
    wa = acc_a & a_wr;
    wb = acc_b & b_wr;
    ra = acc_a & a_rd & ~a_wr;
    rb = acc_b & b_rd & ~b_wr;
    if (ra) begin
      it.data = merged(a_addr, wa, wb);
      it.left = 1; sb[0].push_back(it);
      it.left = 2; sb[2].push_back(it);
    end
    if (rb) begin
      it.data = merged(b_addr, wa, wb);
      it.left = 1; sb[1].push_back(it);
      it.left = 2; sb[3].push_back(it);
    end
    cn = wa & wb & (a_addr == b_addr) & (|(a_be & b_be));
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      if (wb && b_be[b]) ref_mem[b_addr][b*8 +: 8] = b_wd[b*8 +: 8];
    end
    for (int b = 0; b < 2; b++) begin
      if (wa && a_be[b]) ref_mem[a_addr][b*8 +: 8] = a_wd[b*8 +: 8];
    end
    exp_coll = cn;
    if (!reset_req) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < sb[i].size(); j++) begin
          if (sb[i][j].left > 0) sb[i][j].left = sb[i][j].left - 1;
        end
      end
    end
    #1;
    clear_requests();
  endtask

  // Negedge monitor: every cycle, each port's valid must match the
  // scoreboard head being due, and the data must match when it is due.
  always @(negedge clk) begin : monitor
    logic ev;
    for (int i = 0; i < 4; i++) begin
      ev = 1'b0;
      if (!reset && !reset_req && sb[i].size() > 0) ev = (sb[i][0].left == 0);
      checkOutput($sformatf("rdvalid%0d", i), 32'(rvalid[i]), 32'(ev));
      if (ev) begin
        checkOutput($sformatf("rdata%0d", i), 32'(rdat[i]), 32'(sb[i][0].data));
        void'(sb[i].pop_front());
      end
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("wr_coll%0d", k), 32'(coll[k]), 32'(exp_coll & ~reset));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    exp_coll  = 1'b0;
    reset     = 1'b1;
    reset_req = 1'b0;
    a_addr = '0; a_be = '0; a_wd = '0;
    b_addr = '0; b_be = '0; b_wd = '0;
    clear_requests();
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rst_rdata%0d", i), 32'(rdat[i]), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] basic write/read, same-port RAW, back-to-back");
    set_a(0, 1, 6'd5, 16'hBEEF, 2'b11); applyStimulus();
    set_a(1, 0, 6'd5, 16'h0, 2'b00);    applyStimulus();
    set_a(1, 0, 6'd5, 16'h0, 2'b00); set_b(1, 0, 6'd5, 16'h0, 2'b00); applyStimulus();
    set_a(1, 0, 6'd5, 16'h0, 2'b00); applyStimulus();
    repeat (3) applyStimulus();

    $display("[TB] byte enables");
    set_a(0, 1, 6'd7, 16'h1234, 2'b11); applyStimulus();
    set_b(0, 1, 6'd7, 16'hAB00, 2'b10); applyStimulus();
    set_a(1, 0, 6'd7, 16'h0, 2'b00);    applyStimulus();
    set_b(0, 1, 6'd7, 16'h00CD, 2'b01); applyStimulus();
    set_a(1, 0, 6'd7, 16'h0, 2'b00);    applyStimulus();
    set_b(0, 1, 6'd7, 16'hFFFF, 2'b00); applyStimulus();
    set_b(1, 0, 6'd7, 16'h0, 2'b00);    applyStimulus();
    repeat (3) applyStimulus();

    $display("[TB] write collisions");
    set_a(0, 1, 6'd9, 16'h1111, 2'b11); set_b(0, 1, 6'd9, 16'h2222, 2'b11); applyStimulus();
    set_a(1, 0, 6'd9, 16'h0, 2'b00); applyStimulus();
    set_a(0, 1, 6'd9, 16'h1111, 2'b01); set_b(0, 1, 6'd9, 16'h2222, 2'b10); applyStimulus();
    set_b(1, 0, 6'd9, 16'h0, 2'b00); applyStimulus();
    repeat (3) applyStimulus();

    $display("[TB] mixed-port forwarding");
    set_a(0, 1, 6'd3, 16'h0000, 2'b11); applyStimulus();
    set_b(0, 1, 6'd3, 16'h5A5A, 2'b10); set_a(1, 0, 6'd3, 16'h0, 2'b00); applyStimulus();
    set_a(0, 1, 6'd3, 16'h00C3, 2'b01); set_b(1, 0, 6'd3, 16'h0, 2'b00); applyStimulus();
    set_a(1, 0, 6'd3, 16'h0, 2'b00); applyStimulus();
    repeat (3) applyStimulus();

    $display("[TB] read+write same port, clken low");
    set_a(1, 1, 6'd11, 16'h7777, 2'b11); applyStimulus();
    set_a(1, 0, 6'd11, 16'h0, 2'b00); a_ck = 1'b0; applyStimulus();
    set_a(1, 0, 6'd11, 16'h0, 2'b00); applyStimulus();
    repeat (3) applyStimulus();

    $display("[TB] reset_req stall");
    set_a(1, 0, 6'd5, 16'h0, 2'b00); applyStimulus();
    reset_req = 1'b1;
    repeat (3) begin
      set_a(0, 1, 6'd5, 16'h4444, 2'b11); set_b(0, 1, 6'd5, 16'hDEAD, 2'b11); applyStimulus();
    end
    reset_req = 1'b0;
    repeat (2) applyStimulus();
    set_b(1, 0, 6'd5, 16'h0, 2'b00); applyStimulus();
    repeat (3) applyStimulus();

    $display("[TB] async reset mid-read");
    set_a(0, 1, 6'd20, 16'hC0DE, 2'b11); applyStimulus();
    set_a(1, 0, 6'd20, 16'h0, 2'b00);    applyStimulus();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) sb[i].delete();
    exp_coll = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("midrst_rdata%0d", i), 32'(rdat[i]), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus();
    set_a(1, 0, 6'd20, 16'h0, 2'b00); applyStimulus();
    repeat (3) applyStimulus();

    $display("[TB] random traffic");
    for (int i = 0; i < 8; i++) begin
      set_a(0, 1, 6'(i), 16'($urandom), 2'b11); applyStimulus();
    end
    for (int n = 0; n < 60; n++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
            16'($urandom), 2'($urandom_range(0, 3)));
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
            16'($urandom), 2'($urandom_range(0, 3)));
      a_ck = ($urandom_range(0, 7) != 0);
      b_ck = ($urandom_range(0, 7) != 0);
      reset_req = ($urandom_range(0, 7) == 0);
      applyStimulus();
    end
    reset_req = 1'b0;
    repeat (4) applyStimulus();

    checkOutput("sb_drained", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/onchip_sram_dp_pipe.md
Name: onchip_sram_dp_pipe

Overview:
- Parametrised true-dual-port on-chip SRAM with two independent Avalon-MM slave ports (s1, s2) on one clock.
- Successor to the fixed 64x16 dual-port SRAM. Adds generic width and depth, configurable registered read latency, and a readdatavalid handshake.
- Adds deterministic same-address write collision resolution, and mixed-port read-during-write forwarding.
- Sits between the HPS/Nios interconnect and datapath IP that needs a shared scratch buffer.

Parameters:
- DATA_W, 16, data width per port in bits; must be a multiple of 8.
- ADDR_W, 6, word address width; depth is 2**ADDR_W.
- READ_LAT, 1, read latency in cycles; legal values are 1 and 2.
- INIT_FILE, "", hex init file; empty string means contents are zero-initialised in simulation.

Ports:
- clk  in  1  single clock for both ports
- reset  in  1  asynchronous, active-high reset
- reset_req  in  1  global clock-enable inhibit; high freezes the whole block
- chipselect / chipselect2  in  1  port A / port B select
- address / address2  in  ADDR_W  word address
- byteenable / byteenable2  in  DATA_W/8  byte lanes
- read / read2  in  1  read request
- write / write2  in  1  write request
- writedata / writedata2  in  DATA_W  write data
- clken / clken2  in  1  per-port request enable
- readdata / readdata2  out  DATA_W  read data
- readdatavalid / readdatavalid2  out  1  one-cycle read-return strobe
- wr_collision  out  1  pulse: both ports wrote the same address

Behaviour:
- Reset (async, active-high): readdata, readdata2 = 0; readdatavalid, readdatavalid2 = 0; wr_collision = 0; read pipelines flushed. Memory contents are not cleared.
- Request accept, port A: chipselect & clken & ~reset_req. Write if write=1, read if read=1. Port B is identical.
- Read and write asserted on the same port in the same cycle: the write is performed, the read is dropped, and no readdatavalid is produced.
- Write: bytes with byteenable=1 are updated at the clock edge of the accept cycle. Bytes with byteenable=0 are untouched. byteenable=0 on every lane is a no-op write.
- Read accepted at cycle T:
  - readdata is valid and readdatavalid=1 exactly at T+READ_LAT, for one cycle.
  - readdata holds its last value when readdatavalid=0.
  - Back-to-back reads are accepted every cycle (throughput 1 per port).
- Same-port read-after-write: a read at T+1 of an address written at T returns the new data.
- Mixed-port read-during-write (A reads X while B writes X in the same cycle, or the reverse):
  - enabled bytes of the reader's return carry the writer's new data;
  - all other bytes carry the stored data.
- Write collision (both ports write X in the same cycle):
  - per byte, port A wins where both lanes are enabled; a byte takes port B's data where only B is enabled;
  - wr_collision=1 in the following cycle only, and only when the byteenable masks overlap.
- Collision plus read: a read of X by either port in a collision cycle returns the resolved (A-priority) merge.
- reset_req=1:
  - no requests are accepted and no memory writes occur;
  - read pipeline registers and outputs hold;
  - readdatavalid is forced to 0 while reset_req=1. The pending return reasserts when reset_req falls.
- clken=0: the port accepts no request, but its in-flight read pipeline still advances.
- Address wrap: addresses are truncated to ADDR_W. No out-of-range handling.
- Reset asserted mid-read: the pending return is discarded and readdatavalid is never raised for it.

Optional Feature:
- Macro: ONCHIP_SRAM_DP_PARITY_EN.
- Defined:
  - one even-parity bit is stored per byte and written with that byte;
  - the read path recomputes parity;
  - adds outputs parity_err and parity_err2 (1 bit each), valid with readdatavalid/readdatavalid2, reset 0;
  - adds input parity_inject (1 bit). When it is 1 during a write, stored parity is inverted for all enabled bytes.
- Undefined: no parity storage, and the parity ports are absent.

Test Plan:
- Basic write/read: A writes addr 5 = 0xBEEF, be=11; A reads 5 -> readdata=0xBEEF at T+READ_LAT, readdatavalid high 1 cycle; repeat with READ_LAT=2.
- Byte enable: addr 7 = 0x1234; B writes 0xAB00 be=10 -> A reads 0xAB34; B writes 0x00CD be=01 -> 0xABCD.
- Write collision: A writes 9 = 0x1111 be=11, B writes 9 = 0x2222 be=11 same cycle -> wr_collision=1 next cycle, read 9 = 0x1111. Masks A be=01, B be=10 -> 0x2211, wr_collision=0.
- Mixed-port forwarding: addr 3 = 0x0000; same cycle B writes 3 = 0x5A5A be=10, A reads 3 -> A returns 0x5A00.
- reset_req stall: read issued, reset_req=1 for 3 cycles starting T+1 with READ_LAT=2 -> readdatavalid=0 during stall, asserted with correct data the cycle after reset_req falls; writes attempted during stall leave memory unchanged.
- Async reset mid-read: read at T, reset pulse before T+READ_LAT -> readdatavalid stays 0, readdata=0; memory content at that address is preserved after reset.
